// File: rtl/keypad_cmd_queue.sv
// Debounces the keypad scanner's held code, turns changes of the stable key into
// game commands and queues them in a small FIFO drained by a valid/ready consumer.
module keypad_cmd_queue #(
   parameter int STABLE_CYCLES = 100000,
   parameter int CNT_W         = 17,
   parameter int FIFO_DEPTH    = 4,
   parameter int PTR_W         = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       decode,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [2:0]       cmd,
   output logic [3:0]       key_code,
   output logic [PTR_W:0]   fifo_count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       cand_q, cand_d;
   logic [3:0]       acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             base_q, base_d;
   logic             event_d;
   logic [2:0]       ev_cmd;

   logic [6:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   fcount_q, fcount_d;
   logic             ovf_q;
   logic             empty, full, push, pop, wr_en, drop;
   logic [6:0]       head;

   // Two-flop synchroniser: decode is asynchronous to clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= decode;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      base_d  = base_q;
      event_d = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!base_q) begin
         // First stable value after reset is the scanner's idle state, not a press.
         acc_d  = cand_q;
         base_d = 1'b1;
      end else if (cand_q != acc_q) begin
         acc_d   = cand_q;
         event_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= '0;
         cnt_q  <= '0;
         acc_q  <= '0;
         base_q <= 1'b0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         base_q <= base_d;
      end
   end

   always_comb begin
      ev_cmd = 3'd0;
      case (cand_q)
         4'h2:    ev_cmd = 3'd1;
         4'h8:    ev_cmd = 3'd2;
         4'h4:    ev_cmd = 3'd3;
         4'h6:    ev_cmd = 3'd4;
         4'h5:    ev_cmd = 3'd5;
         4'hF:    ev_cmd = 3'd6;
         default: ev_cmd = 3'd0;
      endcase
   end

   assign empty = (fcount_q == '0);
   assign full  = (fcount_q == CNT_FULL);
   assign push  = event_d && (ev_cmd != 3'd0);
   assign pop   = !empty && cmd_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_comb begin
      fcount_d = fcount_q;
      case ({wr_en, pop})
         2'b10:   fcount_d = fcount_q + (PTR_W+1)'(1);
         2'b01:   fcount_d = fcount_q - (PTR_W+1)'(1);
         default: fcount_d = fcount_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q     <= '0;
         rd_q     <= '0;
         fcount_q <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         fcount_q <= fcount_d;
         if (wr_en) begin
            mem_q[wr_q] <= {cand_q, ev_cmd};
            wr_q        <= wr_q + PTR_W'(1);
         end
         if (pop) rd_q <= rd_q + PTR_W'(1);
         if (drop) ovf_q <= 1'b1;
      end
   end

   assign head       = mem_q[rd_q];
   assign cmd_valid  = !empty;
   assign cmd        = empty ? 3'd0 : head[2:0];
   assign key_code   = empty ? 4'd0 : head[6:3];
   assign fifo_count = fcount_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_cmd_queue.sv
// Self-checking bench for keypad_cmd_queue: directed scenarios plus random key
// streams compared against a window-based behavioural model of debounce and queue.
module tb_keypad_cmd_queue;

   localparam int S     = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] decode = 4'd0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [3:0] key_code;
   logic [2:0] fifo_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   keypad_cmd_queue #(
      .STABLE_CYCLES(S),
      .CNT_W(4),
      .FIFO_DEPTH(DEPTH),
      .PTR_W(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .decode(decode),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd(cmd),
      .key_code(key_code),
      .fifo_count(fifo_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   wire [11:0] obs = {cmd_valid, cmd, key_code, fifo_count, overflow};

   // Reference model: a key is accepted once the synchronised value has been seen
   // on S+1 consecutive edges; the reset edge itself counts as a sighting of 0.
   logic [2:0] cmd_map [16];
   logic [3:0] d1, d2, seen, m_acc;
   logic [3:0] win [$];
   logic [6:0] mq [$];
   logic       m_ovf, m_base;
   bit         stable, ev, mpop;

   initial begin
      for (int i = 0; i < 16; i++) cmd_map[i] = 3'd0;
      cmd_map[2] = 3'd1; cmd_map[8] = 3'd2; cmd_map[4] = 3'd3;
      cmd_map[6] = 3'd4; cmd_map[5] = 3'd5; cmd_map[15] = 3'd6;
   end

   always @(posedge clk) begin
      if (rst) begin
         d1 = 0; d2 = 0; m_acc = 0; m_ovf = 0; m_base = 0;
         win = {4'd0};
         mq  = {};
      end else begin
         seen = d2;
         d2   = d1;
         d1   = decode;
         win.push_back(seen);
         if (win.size() > S + 1) void'(win.pop_front());
         stable = (win.size() == S + 1);
         foreach (win[i]) if (win[i] != seen) stable = 0;
         ev = 0;
         if (stable) begin
            if (!m_base) begin
               m_base = 1; m_acc = seen;
            end else if (seen != m_acc) begin
               m_acc = seen; ev = 1;
            end
         end
         mpop = (mq.size() != 0) && cmd_ready;
         if (mpop) void'(mq.pop_front());
         if (ev && cmd_map[seen] != 3'd0) begin
            if (mq.size() < DEPTH) mq.push_back({seen, cmd_map[seen]});
            else m_ovf = 1;
         end
      end
   end

   function automatic logic [11:0] model_out();
      if (mq.size() == 0) return {1'b0, 3'd0, 4'd0, 3'd0, m_ovf};
      return {1'b1, mq[0][2:0], mq[0][6:3], 3'(mq.size()), m_ovf};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; decode = 4'h5; cmd_ready = 1'b1;
      step(); step();
      checks++;
      if (obs !== 12'd0) begin
         errors++; $display("FAIL reset_state got %h expected %h", obs, 12'd0);
      end
      rst = 1'b0; decode = 4'd0; cmd_ready = 1'b0;
   endtask

   task automatic test_latency();
      do_reset();
      repeat (20) step();
      decode = 4'h2;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early edge %0d cmd_valid %b expected 0", i + 21, cmd_valid);
         end
      end
      step();
      checks++;
      if ({cmd_valid, cmd, key_code, fifo_count} !== {1'b1, 3'd1, 4'd2, 3'd1}) begin
         errors++; $display("FAIL latency_push got v=%b cmd=%0d key=%h cnt=%0d expected v=1 cmd=1 key=2 cnt=1",
                            cmd_valid, cmd, key_code, fifo_count);
      end
      cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
   endtask

   task automatic test_glitch();
      do_reset();
      repeat (20) step();
      decode = 4'h8;
      repeat (5) step();
      decode = 4'h0;
      for (int i = 0; i < 25; i++) begin
         step();
         checks++;
         if (fifo_count !== 3'd0 || obs !== model_out()) begin
            errors++; $display("FAIL glitch cyc %0d got %h expected %h", i, obs, model_out());
         end
      end
   endtask

   task automatic test_overflow();
      logic [3:0] keys [5];
      logic [2:0] exp_cmd [4];
      keys = '{4'h4, 4'h6, 4'h5, 4'hF, 4'h2};
      exp_cmd = '{3'd3, 3'd4, 3'd5, 3'd6};
      do_reset();
      repeat (20) step();
      cmd_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         decode = keys[k];
         for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
               errors++; $display("FAIL overflow_fill key %h cyc %0d got %h expected %h", keys[k], i, obs, model_out());
            end
         end
      end
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_full cnt=%0d ovf=%b expected cnt=4 ovf=1", fifo_count, overflow);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cmd !== exp_cmd[k] || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL overflow_pop %0d cmd=%0d v=%b expected cmd=%0d v=1", k, cmd, cmd_valid, exp_cmd[k]);
         end
         cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (fifo_count !== 3'd0 || cmd_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL empty_ready cnt=%0d v=%b ovf=%b expected cnt=0 v=0 ovf=1", fifo_count, cmd_valid, overflow);
         end
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] keys [4];
      logic [2:0] exp_cmd [4];
      keys = '{4'h4, 4'h6, 4'h5, 4'hF};
      exp_cmd = '{3'd4, 3'd5, 3'd6, 3'd1};
      do_reset();
      repeat (20) step();
      for (int k = 0; k < 4; k++) begin
         decode = keys[k];
         repeat (20) step();
      end
      decode = 4'h2;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (fifo_count !== 3'd4 || obs !== model_out()) begin
            errors++; $display("FAIL b2b_wait cyc %0d got %h expected %h", i, obs, model_out());
         end
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      checks++;
      if ({fifo_count, overflow, cmd} !== {3'd4, 1'b0, 3'd4}) begin
         errors++; $display("FAIL b2b_push_pop cnt=%0d ovf=%b cmd=%0d expected cnt=4 ovf=0 cmd=4", fifo_count, overflow, cmd);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cmd !== exp_cmd[k]) begin
            errors++; $display("FAIL b2b_drain %0d cmd=%0d expected %0d", k, cmd, exp_cmd[k]);
         end
         cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
      end
   endtask

   task automatic test_unmapped();
      decode = 4'hA;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (fifo_count !== 3'd0 || obs !== model_out()) begin
            errors++; $display("FAIL unmapped cyc %0d got %h expected %h", i, obs, model_out());
         end
      end
      decode = 4'h2;
      repeat (20) step();
      checks++;
      if ({fifo_count, cmd, key_code, overflow} !== {3'd1, 3'd1, 4'd2, 1'b0}) begin
         errors++; $display("FAIL unmapped_return cnt=%0d cmd=%0d key=%h ovf=%b expected cnt=1 cmd=1 key=2 ovf=0",
                            fifo_count, cmd, key_code, overflow);
      end
      cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] keys [3];
      keys = '{4'h4, 4'h6, 4'h5};
      for (int k = 0; k < 3; k++) begin
         decode = keys[k];
         repeat (20) step();
      end
      decode = 4'h8;
      repeat (5) step();
      checks++;
      if (fifo_count !== 3'd3) begin
         errors++; $display("FAIL reset_mid_pre cnt=%0d expected 3", fifo_count);
      end
      do_reset();
      checks++;
      if (obs !== 12'd0) begin
         errors++; $display("FAIL reset_mid got %h expected %h", obs, 12'd0);
      end
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_baseline cyc %0d v=%b cnt=%0d expected v=0 cnt=0", i, cmd_valid, fifo_count);
         end
      end
      decode = 4'h2;
      repeat (20) step();
      checks++;
      if ({fifo_count, cmd} !== {3'd1, 3'd1}) begin
         errors++; $display("FAIL reset_after cnt=%0d cmd=%0d expected cnt=1 cmd=1", fifo_count, cmd);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            decode = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 24);
         end
         hold--;
         cmd_ready = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 799) == 0);
         step();
         checks++;
         if (obs !== model_out()) begin
            errors++; $display("FAIL random cyc %0d got %h expected %h", i, obs, model_out());
         end
      end
      rst = 1'b0; cmd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_overflow();
      test_back_to_back();
      test_unmapped();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
